// File: rtl/approx_add_pipe.sv
// approx_add_pipe: signed approximate adder (lower-part OR, split carry chain) with an elastic
// valid/ready pipeline. Define APPROX_ADD_STAT_EN to build the txn_cnt/err_sum statistics.
module approx_add_pipe #(
  parameter int W      = 16,
  parameter int K      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   O,
  input  logic         stat_clr,
  output logic [31:0]  txn_cnt,
  output logic [31:0]  err_sum
);
  localparam int LW = (K > 0) ? K : 1;
  localparam int UW = W + 1 - K;
  localparam int CH = (UW + STAGES - 1) / STAGES;
  localparam int PW = CH * STAGES;
  localparam int L  = STAGES - 1;

  function automatic logic [CH:0] add_chunk(input logic [CH-1:0] x, input logic [CH-1:0] y,
                                            input logic ci);
    return {1'b0, x} + {1'b0, y} + {{CH{1'b0}}, ci};
  endfunction

  // Upper operands are sign-extended to PW so every stage adds one equal-width chunk;
  // the low UW bits of the padded sum equal the wrap-around sum at UW bits.
  logic signed [W-K-1:0] a_up, b_up;
  logic        [PW-1:0]  a_ext, b_ext;
  logic        [LW-1:0]  lo_in;
  logic                  c_in;

  assign a_up  = A[W-1:K];
  assign b_up  = B[W-1:K];
  assign a_ext = {{(PW-W+K){a_up[W-K-1]}}, a_up};
  assign b_ext = {{(PW-W+K){b_up[W-K-1]}}, b_up};

  generate
    if (K > 0) begin : g_lo
      assign lo_in = A[LW-1:0] | B[LW-1:0];
      assign c_in  = A[LW-1] & B[LW-1];
    end else begin : g_nolo
      assign lo_in = '0;
      assign c_in  = 1'b0;
    end
  endgenerate

  logic [STAGES-1:0] vld_q, vld_d, ld, adv, en, cy_q, cy_d;
  logic [PW-1:0]     a_q [STAGES];
  logic [PW-1:0]     b_q [STAGES];
  logic [PW-1:0]     s_q [STAGES];
  logic [PW-1:0]     a_d [STAGES];
  logic [PW-1:0]     b_d [STAGES];
  logic [PW-1:0]     s_d [STAGES];
  logic [LW-1:0]     lo_q [STAGES];
  logic [LW-1:0]     lo_d [STAGES];

  // A stage loads when empty or when its content moves on; readiness ripples back from the output.
  always_comb begin
    logic nxt;
    nxt = out_ready;
    for (int s = L; s >= 0; s--) begin
      adv[s] = vld_q[s] & nxt;
      ld[s]  = ~vld_q[s] | adv[s];
      nxt    = ld[s];
    end
  end

  always_comb begin
    logic [PW-1:0] a_src, b_src, s_src;
    logic [LW-1:0] lo_src;
    logic          c_src, v_src;
    logic [CH:0]   r;
    for (int s = 0; s < STAGES; s++) begin
      if (s == 0) begin
        a_src  = a_ext;
        b_src  = b_ext;
        s_src  = '0;
        lo_src = lo_in;
        c_src  = c_in;
        v_src  = in_valid;
      end else begin
        a_src  = a_q[(s > 0) ? s - 1 : 0];
        b_src  = b_q[(s > 0) ? s - 1 : 0];
        s_src  = s_q[(s > 0) ? s - 1 : 0];
        lo_src = lo_q[(s > 0) ? s - 1 : 0];
        c_src  = cy_q[(s > 0) ? s - 1 : 0];
        v_src  = vld_q[(s > 0) ? s - 1 : 0];
      end
      r                 = add_chunk(a_src[s*CH +: CH], b_src[s*CH +: CH], c_src);
      s_src[s*CH +: CH] = r[CH-1:0];
      a_d[s]   = a_src;
      b_d[s]   = b_src;
      s_d[s]   = s_src;
      lo_d[s]  = lo_src;
      cy_d[s]  = r[CH];
      en[s]    = ld[s] & v_src;
      vld_d[s] = ld[s] ? v_src : vld_q[s];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_d;
    for (int s = 0; s < STAGES; s++) begin
      if (en[s]) begin
        a_q[s]  <= a_d[s];
        b_q[s]  <= b_d[s];
        s_q[s]  <= s_d[s];
        lo_q[s] <= lo_d[s];
        cy_q[s] <= cy_d[s];
      end
    end
  end

  logic [W:0] o_raw;
  generate
    if (K > 0) begin : g_o
      assign o_raw = {s_q[L][UW-1:0], lo_q[L]};
    end else begin : g_o_exact
      assign o_raw = s_q[L][UW-1:0];
    end
  endgenerate

  assign out_valid = vld_q[L];
  assign in_ready  = ld[0];
  assign O         = (rst_n && vld_q[L]) ? o_raw : '0;

  logic unused_tail;
  assign unused_tail = ^{a_q[L], b_q[L], s_q[L], lo_q[L], cy_q[L], adv[0]};

`ifdef APPROX_ADD_STAT_EN
  localparam int EW = (W + 3 > 33) ? W + 3 : 33;

  function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic [W+1:0] inc);
    logic [EW-1:0] t;
    t = EW'(acc) + EW'(inc);
    return (|t[EW-1:32]) ? 32'hFFFF_FFFF : t[31:0];
  endfunction

  logic signed [W:0]   ex_in;
  logic signed [W:0]   ex_q [STAGES];
  logic signed [W+1:0] diff;
  logic        [W+1:0] abs_err;
  logic        [31:0]  txn_q, txn_d, err_q, err_d;
  logic                hs;

  assign ex_in = {A[W-1], A} + {B[W-1], B};

  // Exact sum travels with the approximate one so the error is measured on the delivered pair.
  always_ff @(posedge clk) begin
    for (int s = 0; s < STAGES; s++) begin
      if (en[s]) ex_q[s] <= (s == 0) ? ex_in : ex_q[(s > 0) ? s - 1 : 0];
    end
  end

  assign hs      = vld_q[L] & out_ready;
  assign diff    = {ex_q[L][W], ex_q[L]} - {o_raw[W], o_raw};
  assign abs_err = diff[W+1] ? -diff : diff;

  always_comb begin
    txn_d = txn_q;
    err_d = err_q;
    if (stat_clr) begin
      txn_d = hs ? 32'd1 : 32'd0;
      err_d = hs ? sat_add(32'd0, abs_err) : 32'd0;
    end else if (hs) begin
      txn_d = (txn_q == 32'hFFFF_FFFF) ? txn_q : txn_q + 32'd1;
      err_d = sat_add(err_q, abs_err);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txn_q <= '0;
      err_q <= '0;
    end else begin
      txn_q <= txn_d;
      err_q <= err_d;
    end
  end

  assign txn_cnt = txn_q;
  assign err_sum = err_q;
`else
  logic unused_stat;
  assign unused_stat = stat_clr;
  assign txn_cnt     = '0;
  assign err_sum     = '0;
`endif

endmodule
